// File: rtl/keypad_lock_ctrl.sv
// Keypad password-lock controller: N-digit BCD entry with backspace, try counter
// with timed lockout, secret change while unlocked, and a three-tone buzzer sequencer.
module keypad_lock_ctrl #(
  parameter int unsigned DIGITS    = 3,
  parameter logic [4*DIGITS-1:0] SECRET_INIT = 'h246,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned LOCK_SECS = 20,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned KEY_HALF  = 50_000,
  parameter int unsigned KEY_LEN   = 10_000_000,
  parameter int unsigned OK_HALF   = 25_000,
  parameter int unsigned OK_LEN    = 30_000_000,
  parameter int unsigned FAIL_HALF = 100_000,
  parameter int unsigned FAIL_LEN  = 15_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           onehot_i,
  output logic [4*DIGITS-1:0]   disp_o,
  output logic                  unlocked_o,
  output logic                  locked_out_o,
  output logic [3:0]            tries_o,
  output logic [6:0]            lock_remain_o,
  output logic                  buzzer_o
);

  localparam int unsigned DW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned MAX_LEN  = (KEY_LEN > OK_LEN) ?
                                     ((KEY_LEN > FAIL_LEN) ? KEY_LEN : FAIL_LEN) :
                                     ((OK_LEN > FAIL_LEN) ? OK_LEN : FAIL_LEN);
  localparam int unsigned MAX_HALF = (KEY_HALF > OK_HALF) ?
                                     ((KEY_HALF > FAIL_HALF) ? KEY_HALF : FAIL_HALF) :
                                     ((OK_HALF > FAIL_HALF) ? OK_HALF : FAIL_HALF);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned HW = $clog2(MAX_HALF + 1);

  localparam logic [DW-1:0] ALL_F = {DIGITS{4'hF}};
  localparam logic [DW-1:0] ALL_D = {DIGITS{4'hD}};
  localparam logic [DW-1:0] ALL_A = {DIGITS{4'hA}};
  localparam logic [LW-1:0] GAP_LO = LW'(FAIL_LEN / 3);
  localparam logic [LW-1:0] GAP_HI = LW'((2 * FAIL_LEN) / 3);

  typedef enum logic [1:0] {ST_ENTRY, ST_PASS, ST_SET_ENTRY, ST_LOCKOUT} state_e;
  typedef enum logic [1:0] {T_IDLE, T_KEY, T_OK, T_FAIL} tone_e;

  state_e          state_q, state_d;
  tone_e           tone_q, tone_d;
  logic [15:0]     onehot_prev_q;
  logic [DW-1:0]   disp_q, disp_d;
  logic [DW-1:0]   secret_q, secret_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      tries_q, tries_d;
  logic [6:0]      remain_q, remain_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            unlocked_q, locked_q;
  logic [LW-1:0]   dur_q, dur_d, len_m1;
  logic [HW-1:0]   half_q, half_d, half_m1;
  logic            phase_q, phase_d, buzzer_q, buzzer_d;

  logic            evt, key_any, key_digit, key_enter, key_set, key_clear, key_back;
  logic [3:0]      digit;
  logic            full, empty, tick;
  logic            req_key, req_ok, req_fail;
  logic [3:0]      blank;

  // Blank upper nibbles with the remaining seconds as two BCD digits at the bottom.
  function automatic logic [DW-1:0] lock_disp(input logic [6:0] secs);
    logic [DW-1:0] r;
    r      = ALL_F;
    r[7:4] = 4'(secs / 7'd10);
    r[3:0] = 4'(secs % 7'd10);
    return r;
  endfunction

  // Key decode: a single set bit on a previously idle scan word.
  always_comb begin
    evt       = $onehot(onehot_i) && (onehot_prev_q == 16'h0000);
    key_digit = 1'b0;
    key_enter = 1'b0;
    key_set   = 1'b0;
    key_clear = 1'b0;
    key_back  = 1'b0;
    digit     = 4'h0;
    case (onehot_i)
      16'h0008: begin key_digit = 1'b1; digit = 4'd0; end
      16'h0080: begin key_digit = 1'b1; digit = 4'd1; end
      16'h0040: begin key_digit = 1'b1; digit = 4'd2; end
      16'h0020: begin key_digit = 1'b1; digit = 4'd3; end
      16'h0800: begin key_digit = 1'b1; digit = 4'd4; end
      16'h0400: begin key_digit = 1'b1; digit = 4'd5; end
      16'h0200: begin key_digit = 1'b1; digit = 4'd6; end
      16'h8000: begin key_digit = 1'b1; digit = 4'd7; end
      16'h4000: begin key_digit = 1'b1; digit = 4'd8; end
      16'h2000: begin key_digit = 1'b1; digit = 4'd9; end
      16'h0001: key_enter = 1'b1;
      16'h0010: key_set   = 1'b1;
      16'h0100: key_clear = 1'b1;
      16'h1000: key_back  = 1'b1;
      default:  ;
    endcase
    key_digit = key_digit & evt;
    key_enter = key_enter & evt;
    key_set   = key_set & evt;
    key_clear = key_clear & evt;
    key_back  = key_back & evt;
    key_any   = key_digit | key_enter | key_set | key_clear | key_back;
  end

  // Lock state machine: next state, display, counters and tone requests.
  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    secret_d = secret_q;
    count_d  = count_q;
    tries_d  = tries_q;
    remain_d = remain_q;
    pre_d    = '0;
    req_key  = 1'b0;
    req_ok   = 1'b0;
    req_fail = 1'b0;
    full     = (count_q == CW'(DIGITS));
    empty    = (count_q == '0);
    tick     = (pre_q == PW'(CLK_HZ - 1));
    blank    = (state_q == ST_SET_ENTRY) ? 4'hD : 4'hF;

    case (state_q)
      ST_ENTRY, ST_SET_ENTRY: begin
        req_key = key_any & ~(key_digit & full);
        if (key_digit && !full) begin
          disp_d  = {disp_q[DW-5:0], digit};
          count_d = count_q + CW'(1);
        end else if (key_back && !empty) begin
          disp_d  = {blank, disp_q[DW-1:4]};
          count_d = count_q - CW'(1);
        end else if (state_q == ST_ENTRY) begin
          if (key_enter && full) begin
            count_d = '0;
            if (disp_q == secret_q) begin
              state_d = ST_PASS;
              tries_d = 4'd0;
              disp_d  = ALL_A;
              req_ok  = 1'b1;
            end else if (4'(tries_q + 4'd1) == 4'(MAX_TRIES)) begin
              state_d  = ST_LOCKOUT;
              tries_d  = 4'd0;
              remain_d = 7'(LOCK_SECS);
              disp_d   = lock_disp(7'(LOCK_SECS));
              req_fail = 1'b1;
            end else begin
              tries_d  = tries_q + 4'd1;
              disp_d   = ALL_F;
              req_fail = 1'b1;
            end
          end else if (key_clear) begin
            disp_d  = ALL_F;
            count_d = '0;
          end
        end else begin
          if (key_enter && full) begin
            secret_d = disp_q;
            state_d  = ST_ENTRY;
            disp_d   = ALL_F;
            count_d  = '0;
            req_ok   = 1'b1;
          end else if (key_clear) begin
            state_d = ST_PASS;
            disp_d  = ALL_A;
            count_d = '0;
          end
        end
      end
      ST_PASS: begin
        req_key = key_any;
        if (key_set) begin
          state_d = ST_SET_ENTRY;
          disp_d  = ALL_D;
          count_d = '0;
        end else if (key_clear) begin
          state_d = ST_ENTRY;
          disp_d  = ALL_F;
          count_d = '0;
        end
      end
      ST_LOCKOUT: begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        if (tick) begin
          if (remain_q <= 7'd1) begin
            state_d  = ST_ENTRY;
            remain_d = 7'd0;
            disp_d   = ALL_F;
          end else begin
            remain_d = remain_q - 7'd1;
            disp_d   = lock_disp(remain_q - 7'd1);
          end
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Tone sequencer: a new request restarts the tone; FAIL is muted in its middle third.
  always_comb begin
    tone_d  = tone_q;
    dur_d   = dur_q;
    half_d  = half_q;
    phase_d = phase_q;
    case (tone_q)
      T_KEY:   begin len_m1 = LW'(KEY_LEN - 1);  half_m1 = HW'(KEY_HALF - 1);  end
      T_OK:    begin len_m1 = LW'(OK_LEN - 1);   half_m1 = HW'(OK_HALF - 1);   end
      T_FAIL:  begin len_m1 = LW'(FAIL_LEN - 1); half_m1 = HW'(FAIL_HALF - 1); end
      default: begin len_m1 = '0;                half_m1 = '0;                 end
    endcase
    if (req_fail || req_ok || req_key) begin
      tone_d  = req_fail ? T_FAIL : (req_ok ? T_OK : T_KEY);
      dur_d   = '0;
      half_d  = '0;
      phase_d = 1'b1;
    end else if (tone_q != T_IDLE) begin
      if (dur_q == len_m1) begin
        tone_d  = T_IDLE;
        dur_d   = '0;
        half_d  = '0;
        phase_d = 1'b0;
      end else begin
        dur_d = dur_q + LW'(1);
        if (half_q == half_m1) begin
          half_d  = '0;
          phase_d = ~phase_q;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
    end
    buzzer_d = phase_d & ~((tone_d == T_FAIL) && (dur_d >= GAP_LO) && (dur_d < GAP_HI));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ENTRY;
      tone_q        <= T_IDLE;
      onehot_prev_q <= '0;
      disp_q        <= ALL_F;
      secret_q      <= SECRET_INIT;
      count_q       <= '0;
      tries_q       <= 4'd0;
      remain_q      <= 7'd0;
      pre_q         <= '0;
      unlocked_q    <= 1'b0;
      locked_q      <= 1'b0;
      dur_q         <= '0;
      half_q        <= '0;
      phase_q       <= 1'b0;
      buzzer_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      tone_q        <= tone_d;
      onehot_prev_q <= onehot_i;
      disp_q        <= disp_d;
      secret_q      <= secret_d;
      count_q       <= count_d;
      tries_q       <= tries_d;
      remain_q      <= remain_d;
      pre_q         <= pre_d;
      unlocked_q    <= (state_d == ST_PASS);
      locked_q      <= (state_d == ST_LOCKOUT);
      dur_q         <= dur_d;
      half_q        <= half_d;
      phase_q       <= phase_d;
      buzzer_q      <= buzzer_d;
    end
  end

  assign disp_o        = disp_q;
  assign unlocked_o    = unlocked_q;
  assign locked_out_o  = locked_q;
  assign tries_o       = tries_q;
  assign lock_remain_o = remain_q;
  assign buzzer_o      = buzzer_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with shortened timing parameters.
module tb_keypad_lock_ctrl;

  localparam int unsigned DIGITS = 3;
  localparam int K_ENTER = 0;
  localparam int K_SET   = 4;
  localparam int K_CLEAR = 8;
  localparam int K_BACK  = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] onehot;
  logic [11:0] disp;
  logic        unlocked, locked_out, buzzer;
  logic [3:0]  tries;
  logic [6:0]  lock_remain;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  keypad_lock_ctrl #(
    .DIGITS(DIGITS), .SECRET_INIT(12'h246), .MAX_TRIES(3), .LOCK_SECS(3),
    .CLK_HZ(100), .KEY_HALF(2), .KEY_LEN(8), .OK_HALF(3), .OK_LEN(24),
    .FAIL_HALF(2), .FAIL_LEN(30)
  ) dut (
    .clk(clk), .rst_n(rst_n), .onehot_i(onehot), .disp_o(disp),
    .unlocked_o(unlocked), .locked_out_o(locked_out), .tries_o(tries),
    .lock_remain_o(lock_remain), .buzzer_o(buzzer)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int dbit(input int d);
    case (d)
      0: return 3;   1: return 7;   2: return 6;   3: return 5;   4: return 11;
      5: return 10;  6: return 9;   7: return 15;  8: return 14;  default: return 13;
    endcase
  endfunction

  // One idle cycle, one key cycle; returns on the falling edge after the event edge.
  task automatic press_bit(input int b);
    @(negedge clk);
    onehot    = '0;
    onehot[b] = 1'b1;
    @(negedge clk);
    onehot = '0;
  endtask

  task automatic press_digit(input int d);
    press_bit(dbit(d));
  endtask

  task automatic enter_code(input int a, input int b, input int c);
    press_digit(a);
    press_digit(b);
    press_digit(c);
    press_bit(K_ENTER);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    onehot = '0;
    wait_n(3);
    check("rst_disp", 32'(disp), 32'hFFF);
    check("rst_unlocked", 32'(unlocked), 32'h0);
    check("rst_locked", 32'(locked_out), 32'h0);
    check("rst_tries", 32'(tries), 32'h0);
    check("rst_remain", 32'(lock_remain), 32'h0);
    check("rst_buzzer", 32'(buzzer), 32'h0);
    rst_n = 1'b1;
    wait_n(2);

    // Correct code and OK tone shape
    press_digit(2);
    check("d2_disp", 32'(disp), 32'hFF2);
    check("d2_click", 32'(buzzer), 32'h1);
    press_digit(4);
    check("d4_disp", 32'(disp), 32'hF24);
    press_digit(6);
    check("d6_disp", 32'(disp), 32'h246);
    press_bit(K_ENTER);
    check("ok_disp", 32'(disp), 32'hAAA);
    check("ok_unlocked", 32'(unlocked), 32'h1);
    check("ok_tries", 32'(tries), 32'h0);
    check("ok_buz0", 32'(buzzer), 32'h1);
    wait_n(3);
    check("ok_buz3", 32'(buzzer), 32'h0);
    wait_n(3);
    check("ok_buz6", 32'(buzzer), 32'h1);
    wait_n(14);
    check("ok_buz20", 32'(buzzer), 32'h1);
    wait_n(4);
    check("ok_buz24_idle", 32'(buzzer), 32'h0);
    press_bit(K_CLEAR);
    check("relock_unlocked", 32'(unlocked), 32'h0);
    check("relock_disp", 32'(disp), 32'hFFF);

    // Wrong codes, FAIL gap, lockout countdown
    enter_code(1, 2, 3);
    check("w1_tries", 32'(tries), 32'h1);
    check("w1_disp", 32'(disp), 32'hFFF);
    check("fail_buz0", 32'(buzzer), 32'h1);
    wait_n(8);
    check("fail_buz8", 32'(buzzer), 32'h1);
    wait_n(4);
    check("fail_buz12_gap", 32'(buzzer), 32'h0);
    wait_n(8);
    check("fail_buz20", 32'(buzzer), 32'h1);
    enter_code(1, 2, 3);
    check("w2_tries", 32'(tries), 32'h2);
    enter_code(1, 2, 3);
    check("lo_locked", 32'(locked_out), 32'h1);
    check("lo_tries", 32'(tries), 32'h0);
    check("lo_disp", 32'(disp), 32'hF03);
    press_digit(5);
    check("lo_key_disp", 32'(disp), 32'hF03);
    check("lo_key_remain", 32'(lock_remain), 32'h3);
    wait_n(96);
    check("lo_remain_98", 32'(lock_remain), 32'h3);
    wait_n(2);
    check("lo_remain_100", 32'(lock_remain), 32'h2);
    check("lo_disp_100", 32'(disp), 32'hF02);
    wait_n(199);
    check("lo_remain_299", 32'(lock_remain), 32'h1);
    check("lo_locked_299", 32'(locked_out), 32'h1);
    wait_n(1);
    check("lo_exit_locked", 32'(locked_out), 32'h0);
    check("lo_exit_disp", 32'(disp), 32'hFFF);
    check("lo_exit_remain", 32'(lock_remain), 32'h0);

    // Digit entry with backspace and overflow
    press_digit(7);
    press_digit(8);
    check("e78", 32'(disp), 32'hF78);
    press_bit(K_BACK);
    check("eback", 32'(disp), 32'hFF7);
    press_digit(9);
    check("e79", 32'(disp), 32'hF79);
    press_digit(9);
    check("e799", 32'(disp), 32'h799);
    wait_n(10);
    press_digit(5);
    check("eover_disp", 32'(disp), 32'h799);
    check("eover_notone", 32'(buzzer), 32'h0);
    press_bit(K_BACK);
    press_bit(K_BACK);
    press_bit(K_BACK);
    check("eback3", 32'(disp), 32'hFFF);
    press_bit(K_BACK);
    check("eback_empty", 32'(disp), 32'hFFF);
    press_digit(1);
    press_bit(K_ENTER);
    check("eshort_disp", 32'(disp), 32'hFF1);
    check("eshort_tries", 32'(tries), 32'h0);
    press_bit(K_CLEAR);
    check("eclear", 32'(disp), 32'hFFF);

    // Secret change
    enter_code(2, 4, 6);
    check("s_unlock", 32'(unlocked), 32'h1);
    press_bit(K_SET);
    check("s_set_disp", 32'(disp), 32'hDDD);
    check("s_set_unlocked", 32'(unlocked), 32'h0);
    press_digit(9);
    check("s_d9", 32'(disp), 32'hDD9);
    press_bit(K_BACK);
    check("s_back", 32'(disp), 32'hDDD);
    press_digit(1);
    press_digit(3);
    press_digit(5);
    check("s_135", 32'(disp), 32'h135);
    press_bit(K_ENTER);
    check("s_store_disp", 32'(disp), 32'hFFF);
    check("s_store_unlocked", 32'(unlocked), 32'h0);
    check("s_store_tone", 32'(buzzer), 32'h1);
    enter_code(2, 4, 6);
    check("s_old_tries", 32'(tries), 32'h1);
    check("s_old_unlocked", 32'(unlocked), 32'h0);
    enter_code(1, 3, 5);
    check("s_new_unlocked", 32'(unlocked), 32'h1);
    check("s_new_tries", 32'(tries), 32'h0);
    press_bit(K_SET);
    press_digit(7);
    press_bit(K_CLEAR);
    check("s_abort_unlocked", 32'(unlocked), 32'h1);
    check("s_abort_disp", 32'(disp), 32'hAAA);
    press_bit(K_CLEAR);
    check("s_relock", 32'(disp), 32'hFFF);

    // Held key and multi-bit words
    @(negedge clk);
    onehot = 16'h0008;
    wait_n(20);
    check("hold_disp", 32'(disp), 32'hFF0);
    onehot = 16'h0009;
    wait_n(3);
    check("hold_multi", 32'(disp), 32'hFF0);
    onehot = '0;
    wait_n(2);
    onehot = 16'h0009;
    wait_n(3);
    check("multi_disp", 32'(disp), 32'hFF0);
    onehot = '0;
    press_bit(K_CLEAR);

    // Asynchronous reset mid-tone and mid-set
    enter_code(1, 3, 5);
    check("r_unlock", 32'(unlocked), 32'h1);
    check("r_tone", 32'(buzzer), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("r_async_buz", 32'(buzzer), 32'h0);
    check("r_async_disp", 32'(disp), 32'hFFF);
    check("r_async_unlocked", 32'(unlocked), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(1, 3, 5);
    check("r_newsecret_tries", 32'(tries), 32'h1);
    enter_code(2, 4, 6);
    check("r_init_unlocked", 32'(unlocked), 32'h1);
    check("r_init_tries", 32'(tries), 32'h0);
    press_bit(K_SET);
    press_digit(1);
    press_digit(3);
    check("r_set_disp", 32'(disp), 32'hD13);
    #2 rst_n = 1'b0;
    #1;
    check("r_set_async_disp", 32'(disp), 32'hFFF);
    check("r_set_async_buz", 32'(buzzer), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    enter_code(2, 4, 6);
    check("r_set_unlock", 32'(unlocked), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
